gcd_operand_feeder: RTL and testbench

- Upstream feeder for the GCD compute unit.
- Buffers operand pairs in a small FIFO and presents them one at a time on the GCD In_A/In_B/In_ready interface.
- Waits for the GCD result, acknowledges it with Result_taken, and holds it in an output register until the consumer accepts it.
- Decouples bursty operand producers from the multi-cycle GCD iteration.

---
 rtl/gcd_operand_feeder_pkg.sv | 15 +
 rtl/gcd_pair_fifo.sv | 62 ++++++
 rtl/gcd_operand_feeder.sv | 126 ++++++++++++
 tb/tb_gcd_operand_feeder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_operand_feeder_pkg.sv
// Shared definitions for the GCD operand feeder: FSM state encoding and
// default sizing, so RTL and benches decode states the same way.
package gcd_operand_feeder_pkg;

   localparam int DEFAULT_NUM_OF_BITS = 5;
   localparam int DEFAULT_DEPTH       = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      ACK   = 2'd3
   } feeder_state_t;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Synchronous FIFO holding packed {A,B} operand pairs. DEPTH must be a
// power of two (>= 2) so the pointers wrap by plain overflow.
module gcd_pair_fifo #(
   parameter int W     = 10,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wr_data,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);

   localparam int          AW         = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   // Full/empty come from the registered count, so a push while full is
   // refused even if a pop happens in the same cycle.
   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array write port.
   always_ff @(posedge clk) begin
      // NOTE: the data array is deliberately not reset; the pointers and
      // count define which entries are meaningful, and leaving it out keeps
      // it mappable to plain RAM.
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/gcd_operand_feeder.sv
// Feeds buffered operand pairs to the GCD unit one at a time, acknowledges
// each result and holds it in an output register until the consumer takes it.
module gcd_operand_feeder
   import gcd_operand_feeder_pkg::*;
#(
   parameter int numOfBits = DEFAULT_NUM_OF_BITS,
   parameter int DEPTH     = DEFAULT_DEPTH
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 Wr_en,
   input  logic [numOfBits-1:0] Wr_A,
   input  logic [numOfBits-1:0] Wr_B,
   output logic                 Full,
   output logic                 Overflow,
   output logic [numOfBits-1:0] In_A,
   output logic [numOfBits-1:0] In_B,
   output logic                 In_ready,
   input  logic                 Gcd_done,
   input  logic [numOfBits-1:0] Result,
   output logic                 Result_taken,
   output logic [numOfBits-1:0] Res_out,
   output logic                 Res_valid,
   input  logic                 Res_ack
);

   feeder_state_t              state_q, state_d;
   logic [2*numOfBits-1:0]     fifo_rd_data;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       fifo_pop;
   logic                       capture;
   logic [numOfBits-1:0]       in_a_d, in_b_d, res_out_d;
   logic                       in_ready_d, taken_d, res_valid_d, overflow_d;

   gcd_pair_fifo #(
      .W     (2*numOfBits),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (Clk),
      .rst     (Rst),
      .push    (Wr_en),
      .pop     (fifo_pop),
      .wr_data ({Wr_A, Wr_B}),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign Full = fifo_full;

   // Next-state and next-output logic for the issue/wait/acknowledge sequence.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      in_a_d      = In_A;
      in_b_d      = In_B;
      in_ready_d  = 1'b0;
      taken_d     = Result_taken;
      res_out_d   = Res_out;
      res_valid_d = Res_valid;
      fifo_pop    = 1'b0;
      capture     = 1'b0;
      overflow_d  = Overflow | (Wr_en & fifo_full);

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               in_a_d     = fifo_rd_data[2*numOfBits-1:numOfBits];
               in_b_d     = fifo_rd_data[numOfBits-1:0];
               in_ready_d = 1'b1;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            state_d = BUSY;
         end
         BUSY: begin
            // Only take the result once the output register can hold it.
            if (Gcd_done && (!Res_valid || Res_ack)) begin
               capture     = 1'b1;
               res_out_d   = Result;
               res_valid_d = 1'b1;
               taken_d     = 1'b1;
               state_d     = ACK;
            end
         end
         ACK: begin
            if (!Gcd_done) begin
               taken_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Consumer acceptance empties the register unless a new value lands.
      if (Res_ack && !capture) res_valid_d = 1'b0;
   end

   // Register the FSM state and every externally visible output.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q      <= IDLE;
         In_A         <= '0;
         In_B         <= '0;
         In_ready     <= 1'b0;
         Result_taken <= 1'b0;
         Res_out      <= '0;
         Res_valid    <= 1'b0;
         Overflow     <= 1'b0;
      end else begin
         state_q      <= state_d;
         In_A         <= in_a_d;
         In_B         <= in_b_d;
         In_ready     <= in_ready_d;
         Result_taken <= taken_d;
         Res_out      <= res_out_d;
         Res_valid    <= res_valid_d;
         Overflow     <= overflow_d;
      end
   end

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Self-checking bench for gcd_operand_feeder: behavioural GCD responder,
// scoreboard of expected results, directed scenarios.
module tb_gcd_operand_feeder;
   import gcd_operand_feeder_pkg::*;

   localparam int W     = 5;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         wr_en;
   logic [W-1:0] wr_a, wr_b;
   logic         full, overflow;
   logic [W-1:0] in_a, in_b;
   logic         in_ready;
   logic         gcd_done;
   logic [W-1:0] result;
   logic         result_taken;
   logic [W-1:0] res_out;
   logic         res_valid;
   logic         res_ack;

   logic         resp_en;
   int           n_cmp = 0;
   int           n_err = 0;
   int           ir_count = 0;
   logic         ir_prev = 1'b0;
   logic         full_seen = 1'b0;
   logic [W-1:0] sb [$];

   gcd_operand_feeder #(
      .numOfBits (W),
      .DEPTH     (DEPTH)
   ) dut (
      .Clk          (clk),
      .Rst          (rst),
      .Wr_en        (wr_en),
      .Wr_A         (wr_a),
      .Wr_B         (wr_b),
      .Full         (full),
      .Overflow     (overflow),
      .In_A         (in_a),
      .In_B         (in_b),
      .In_ready     (in_ready),
      .Gcd_done     (gcd_done),
      .Result       (result),
      .Result_taken (result_taken),
      .Res_out      (res_out),
      .Res_valid    (res_valid),
      .Res_ack      (res_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] gcd_model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Drive one push; called at posedge+1, returns at the next posedge+1.
   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input bit accepted);
      wr_en = 1'b1;
      wr_a  = a;
      wr_b  = b;
      if (accepted) sb.push_back(gcd_model(a, b));
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_drain_timeout"}, (n < 2000), 1);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gcd_done(input logic level, input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (gcd_done !== level && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_gcd_done_timeout"}, (n < 100), 1);
   endtask

   // Scoreboard monitor: compares each accepted result, tracks In_ready pulses.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            if (res_valid && res_ack) begin
               check("sb_has_entry", (sb.size() > 0), 1);
               if (sb.size() > 0) check("res_out", res_out, sb.pop_front());
            end
            if (in_ready) begin
               ir_count++;
               if (ir_prev) check("in_ready_single_cycle", 0, 1);
            end
            if (full) full_seen = 1'b1;
            ir_prev = in_ready;
         end else begin
            ir_prev = 1'b0;
         end
      end
   end

   // Behavioural GCD unit: raises Gcd_done 3 cycles after In_ready, holds it
   // until Result_taken is seen, and is cleared by Rst.
   initial begin
      logic [W-1:0] ra, rb;
      int n;
      gcd_done = 1'b0;
      result   = '0;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && in_ready === 1'b1) begin
            ra = in_a;
            rb = in_b;
            n  = 0;
            while (!rst && (n < 3 || !resp_en)) begin
               @(posedge clk);
               n++;
            end
            if (!rst) begin
               #1;
               gcd_done = 1'b1;
               result   = gcd_model(ra, rb);
               n = 0;
               while (!rst && result_taken !== 1'b1 && n < 200) begin
                  @(negedge clk);
                  n++;
               end
               if (!rst) begin
                  check("result_taken_timeout", (n < 200), 1);
                  @(posedge clk);
                  #1;
               end
            end
            gcd_done = 1'b0;
         end
      end
   end

   initial begin
      int base;
      rst     = 1'b0;
      wr_en   = 1'b0;
      wr_a    = '0;
      wr_b    = '0;
      res_ack = 1'b1;
      resp_en = 1'b1;
      #1 rst = 1'b1;
      #2;

      // Reset state
      check("rst_in_a", in_a, 0);
      check("rst_in_b", in_b, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_result_taken", result_taken, 0);
      check("rst_res_out", res_out, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_full", full, 0);
      check("rst_overflow", overflow, 0);
      check("rst_state", dut.state_q, IDLE);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // Single pair: latency and handshake
      push(5'd6, 5'd3, 1'b1);
      @(negedge clk);
      check("t1_in_ready_early", in_ready, 0);
      @(negedge clk);
      check("t1_in_ready_pulse", in_ready, 1);
      check("t1_in_a", in_a, 6);
      check("t1_in_b", in_b, 3);
      @(negedge clk);
      check("t1_in_ready_drop", in_ready, 0);
      wait_gcd_done(1'b1, "t1");
      check("t1_res_valid_before", res_valid, 0);
      @(negedge clk);
      check("t1_res_valid", res_valid, 1);
      check("t1_res_out", res_out, 3);
      check("t1_taken_high", result_taken, 1);
      wait_gcd_done(1'b0, "t1");
      check("t1_taken_held", result_taken, 1);
      @(negedge clk);
      check("t1_taken_low", result_taken, 0);
      wait_drain("t1");

      // Back-to-back pushes
      base      = ir_count;
      full_seen = 1'b0;
      push(5'd2, 5'd7, 1'b1);
      push(5'd30, 5'd20, 1'b1);
      push(5'd5, 5'd10, 1'b1);
      push(5'd11, 5'd11, 1'b1);
      wait_drain("t2");
      check("t2_in_ready_pulses", ir_count - base, 4);
      check("t2_full_never", full_seen, 0);

      // Overflow: responder stalled, one pair in flight, four queued
      base    = ir_count;
      resp_en = 1'b0;
      push(5'd12, 5'd18, 1'b1);
      push(5'd14, 5'd21, 1'b1);
      push(5'd9, 5'd27, 1'b1);
      push(5'd25, 5'd15, 1'b1);
      check("t3_full_before_5th", full, 0);
      push(5'd16, 5'd12, 1'b1);
      check("t3_full_after_5th", full, 1);
      check("t3_overflow_clear", overflow, 0);
      push(5'd31, 5'd1, 1'b0);
      check("t3_overflow_set", overflow, 1);
      check("t3_full_still", full, 1);
      resp_en = 1'b1;
      wait_drain("t3");
      check("t3_in_ready_pulses", ir_count - base, 5);
      check("t3_full_cleared", full, 0);
      check("t3_overflow_sticky", overflow, 1);

      // Back-pressure on the output register
      base    = ir_count;
      res_ack = 1'b0;
      push(5'd6, 5'd3, 1'b1);
      push(5'd28, 5'd0, 1'b1);
      begin
         int n;
         n = 0;
         while (ir_count - base < 2 && n < 200) begin
            @(negedge clk);
            n++;
         end
         check("t4_second_issue_timeout", (n < 200), 1);
      end
      wait_gcd_done(1'b1, "t4");
      repeat (3) @(negedge clk);
      check("t4_state_busy", dut.state_q, BUSY);
      check("t4_taken_low", result_taken, 0);
      check("t4_res_out_held", res_out, 3);
      check("t4_res_valid_held", res_valid, 1);
      @(posedge clk);
      #1 res_ack = 1'b1;
      @(posedge clk);
      #1 res_ack = 1'b0;
      check("t4_res_valid_kept", res_valid, 1);
      check("t4_res_out_new", res_out, 28);
      check("t4_taken_high", result_taken, 1);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      res_ack = 1'b1;
      wait_drain("t4");

      // Reset while BUSY with two pairs queued
      resp_en = 1'b0;
      push(5'd9, 5'd3, 1'b1);
      push(5'd8, 5'd4, 1'b1);
      push(5'd10, 5'd5, 1'b1);
      repeat (6) begin
         @(posedge clk);
         #1;
      end
      check("t5_state_busy", dut.state_q, BUSY);
      #2 rst = 1'b1;
      #1;
      check("t5_in_a", in_a, 0);
      check("t5_in_b", in_b, 0);
      check("t5_in_ready", in_ready, 0);
      check("t5_result_taken", result_taken, 0);
      check("t5_res_out", res_out, 0);
      check("t5_res_valid", res_valid, 0);
      check("t5_full", full, 0);
      check("t5_overflow", overflow, 0);
      check("t5_fifo_empty", dut.fifo_empty, 1);
      check("t5_state_idle", dut.state_q, IDLE);
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      resp_en = 1'b1;
      base    = ir_count;
      repeat (10) @(negedge clk);
      check("t5_no_issue_after_rst", ir_count - base, 0);
      @(posedge clk);
      #1;

      // Wrap-around: nine pairs at a steady rate
      base = ir_count;
      begin
         logic [W-1:0] wa [9];
         logic [W-1:0] wb [9];
         wa = '{5'd9, 5'd12, 5'd15, 5'd7, 5'd16, 5'd13, 5'd18, 5'd17, 5'd4};
         wb = '{5'd6, 5'd8, 5'd10, 5'd21, 5'd24, 5'd26, 5'd27, 5'd0, 5'd2};
         for (int i = 0; i < 9; i++) begin
            push(wa[i], wb[i], 1'b1);
            repeat (6) begin
               @(posedge clk);
               #1;
            end
         end
      end
      wait_drain("t6");
      check("t6_in_ready_pulses", ir_count - base, 9);
      check("t6_overflow_clear", overflow, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
